// File: rtl/fbuf_writer.sv
// fbuf_writer: command-driven write engine for the 64x64 HUB75 framebuffer.
// It turns PIXEL / FILL / HLINE commands into one framebuffer write per cycle.
// The write address uses the display controller's split:
// {half, row-in-half, column}, which is simply {y, x}.
module fbuf_writer #(
  parameter int COLOR_W = 4,
  parameter int COORD_W = 6,
  parameter int ADDR_W  = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [COORD_W-1:0] cmd_x,
  input  logic [COORD_W-1:0] cmd_y,
  input  logic [COORD_W:0]   cmd_len,
  input  logic [COLOR_W-1:0] cmd_color,
  output logic [ADDR_W-1:0]  waddr,
  output logic [COLOR_W-1:0] din,
  output logic               we,
  output logic               busy,
  output logic               done
);

  // Remaining-write counter is one bit wider than the address, so a full
  // 4096-write fill is counted without wrapping.
  localparam int CNT_W = ADDR_W + 1;
  localparam int LEN_W = COORD_W + 1;
  localparam logic [LEN_W-1:0] COLS   = LEN_W'(1) << COORD_W;
  localparam logic [CNT_W-1:0] FILL_N = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic {IDLE, RUN} state_t;
  typedef enum logic [1:0] {OP_PIXEL, OP_FILL, OP_HLINE, OP_NOP} op_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic [ADDR_W-1:0]  waddr_d;
  logic [COLOR_W-1:0] din_d;
  logic               we_d, busy_d, done_d;

  logic [LEN_W-1:0]   line_sum, line_end, line_n;
  logic [CNT_W-1:0]   first_n;
  logic [ADDR_W-1:0]  first_addr;

  assign cmd_ready = (state_q == IDLE) && rst;

  // Write count and first address of the command currently presented.
  always_comb begin
    // NOTE: every signal gets a default before the case so no latch is inferred.
    line_sum   = {1'b0, cmd_x} + cmd_len;
    line_end   = (line_sum > COLS) ? COLS : line_sum;
    line_n     = line_end - {1'b0, cmd_x};
    first_n    = '0;
    first_addr = {cmd_y, cmd_x};
    case (op_t'(cmd_op))
      OP_PIXEL: first_n = CNT_W'(1);
      OP_FILL: begin
        first_n    = FILL_N;
        first_addr = '0;
      end
      OP_HLINE: first_n = CNT_W'(line_n);
      default:  first_n = '0;
    endcase
  end

  // Next-state and next-output logic: load on acceptance, then step one
  // address per cycle until the write flagged as last has been issued.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    waddr_d = waddr;
    din_d   = din;
    we_d    = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          state_d = RUN;
          busy_d  = 1'b1;
          we_d    = (first_n != '0);
          done_d  = (first_n <= CNT_W'(1));
          waddr_d = first_addr;
          din_d   = cmd_color;
          rem_d   = (first_n == '0) ? '0 : first_n - CNT_W'(1);
        end
      end
      RUN: begin
        if (done) begin
          state_d = IDLE;
        end else begin
          // HLINE is pre-clipped, so +1 never crosses a row boundary.
          busy_d  = 1'b1;
          we_d    = 1'b1;
          waddr_d = waddr + ADDR_W'(1);
          rem_d   = rem_q - CNT_W'(1);
          done_d  = (rem_q == CNT_W'(1));
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (!rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      waddr   <= '0;
      din     <= '0;
      we      <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      waddr   <= waddr_d;
      din     <= din_d;
      we      <= we_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

endmodule

// File: tb/tb_fbuf_writer.sv
// Self-checking bench for fbuf_writer: directed scenarios plus randomized
// commands, compared against a pixel-list model of each drawing command.
module tb_fbuf_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [5:0]  cmd_x, cmd_y;
  logic [6:0]  cmd_len;
  logic [3:0]  cmd_color;
  logic [11:0] waddr;
  logic [3:0]  din;
  logic        we, busy, done;

  int checks = 0;
  int errors = 0;

  // Observations of one command, filled by run_cmd.
  int       obs_addr[$];
  int       obs_din[$];
  int       obs_cycles;
  bit       obs_timeout, obs_last_we, obs_busy_bad, obs_ready_bad;
  logic     obs_ready_after, obs_we_after;
  // Model output: the ordered list of addresses a command must write.
  int       exp_addr[$];

  fbuf_writer #(.COLOR_W(4), .COORD_W(6), .ADDR_W(12)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_len(cmd_len),
    .cmd_color(cmd_color), .waddr(waddr), .din(din), .we(we),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pixel-list model: which framebuffer cells a command paints, in order.
  task automatic model(input int op, input int x, input int y, input int len);
    exp_addr.delete();
    case (op)
      0: exp_addr.push_back(y * 64 + x);
      1: for (int a = 0; a < 4096; a++) exp_addr.push_back(a);
      2: for (int c = x; c < x + len && c < 64; c++) exp_addr.push_back(y * 64 + c);
      default: ;
    endcase
  endtask

  // Index of first disagreement between observed and model lists, -1 if equal.
  function automatic int first_diff();
    if (obs_addr.size() != exp_addr.size()) return 0;
    foreach (obs_addr[i]) if (obs_addr[i] != exp_addr[i]) return i;
    return -1;
  endfunction

  function automatic int din_bad(input int color);
    int n = 0;
    foreach (obs_din[i]) if (obs_din[i] != color) n++;
    return n;
  endfunction

  // Issue one command, record every write until done, then one extra cycle.
  task automatic run_cmd(input logic [1:0] op, input logic [5:0] x, input logic [5:0] y,
                         input logic [6:0] len, input logic [3:0] color);
    int guard;
    obs_addr.delete();
    obs_din.delete();
    obs_cycles = 0; obs_timeout = 0; obs_last_we = 0;
    obs_busy_bad = 0; obs_ready_bad = 0;
    cmd_op = op; cmd_x = x; cmd_y = y; cmd_len = len; cmd_color = color;
    cmd_valid = 1'b1;
    guard = 0;
    while (cmd_ready !== 1'b1 && guard < 5000) begin tick(); guard++; end
    if (cmd_ready !== 1'b1) begin
      obs_timeout = 1;
      cmd_valid = 1'b0;
      return;
    end
    tick();
    // Scramble the payload to show the engine latched it at acceptance.
    cmd_valid = 1'b0;
    cmd_op = 2'($urandom); cmd_x = 6'($urandom); cmd_y = 6'($urandom);
    cmd_len = 7'($urandom); cmd_color = 4'($urandom);
    guard = 0;
    while (1) begin
      obs_cycles++;
      if (we === 1'b1) begin
        obs_addr.push_back(int'(waddr));
        obs_din.push_back(int'(din));
      end
      if (busy !== 1'b1) obs_busy_bad = 1;
      if (cmd_ready !== 1'b0) obs_ready_bad = 1;
      if (done === 1'b1) begin obs_last_we = we; break; end
      if (guard >= 5000) begin obs_timeout = 1; break; end
      guard++;
      tick();
    end
    tick();
    obs_ready_after = cmd_ready;
    obs_we_after = we;
  endtask

  task automatic test_reset();
    rst = 1'b0; cmd_valid = 1'b1;
    cmd_op = 2'd0; cmd_x = 6'd1; cmd_y = 6'd1; cmd_len = 7'd1; cmd_color = 4'hF;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (cmd_ready !== 1'b0 || we !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold cyc%0d: cmd_ready=%b we=%b, required 0 0", i, cmd_ready, we);
      end
    end
    rst = 1'b1; cmd_valid = 1'b0;
    #1;
    checks++;
    if (cmd_ready !== 1'b1 || waddr !== 12'h0 || din !== 4'h0 || we !== 1'b0 ||
        busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: ready=%b waddr=%h din=%h we=%b busy=%b done=%b, required 1 000 0 0 0 0",
               cmd_ready, waddr, din, we, busy, done);
    end
  endtask

  task automatic test_pixel();
    run_cmd(2'b00, 6'd5, 6'd40, 7'd0, 4'hA);
    model(0, 5, 40, 0);
    checks++;
    if (obs_timeout || obs_addr.size() != 1 || obs_addr[0] != 'hA05 || first_diff() != -1) begin
      errors++;
      $display("FAIL pixel_addr: writes=%0d first=%h, required 1 write at a05",
               obs_addr.size(), obs_addr.size() ? obs_addr[0] : -1);
    end
    checks++;
    if (din_bad(4'hA) != 0 || obs_cycles != 1 || obs_last_we !== 1'b1) begin
      errors++;
      $display("FAIL pixel_timing: cycles=%0d done_with_we=%b bad_din=%0d, required 1 1 0",
               obs_cycles, obs_last_we, din_bad(4'hA));
    end
    checks++;
    if (obs_ready_after !== 1'b1 || obs_we_after !== 1'b0) begin
      errors++;
      $display("FAIL pixel_after: ready=%b we=%b, required 1 0", obs_ready_after, obs_we_after);
    end
  endtask

  task automatic test_fill();
    run_cmd(2'b01, 6'($urandom), 6'($urandom), 7'($urandom), 4'h3);
    model(1, 0, 0, 0);
    checks++;
    if (obs_timeout || first_diff() != -1) begin
      errors++;
      $display("FAIL fill_addr: writes=%0d first_diff=%0d, required 4096 ascending from 000",
               obs_addr.size(), first_diff());
    end
    checks++;
    if (din_bad(3) != 0 || obs_cycles != 4096 || obs_last_we !== 1'b1 ||
        obs_busy_bad || obs_ready_bad) begin
      errors++;
      $display("FAIL fill_timing: cycles=%0d bad_din=%0d done_with_we=%b busy_bad=%b ready_bad=%b, required 4096 0 1 0 0",
               obs_cycles, din_bad(3), obs_last_we, obs_busy_bad, obs_ready_bad);
    end
    checks++;
    if (obs_ready_after !== 1'b1) begin
      errors++;
      $display("FAIL fill_after: ready=%b, required 1", obs_ready_after);
    end
  endtask

  task automatic test_hline_clip();
    run_cmd(2'b10, 6'd60, 6'd0, 7'd10, 4'h7);
    model(2, 60, 0, 10);
    checks++;
    if (obs_timeout || first_diff() != -1 || obs_addr.size() != 4) begin
      errors++;
      $display("FAIL hline_clip: writes=%0d first_diff=%0d, required 4 writes 03c..03f",
               obs_addr.size(), first_diff());
    end
    checks++;
    if (din_bad(7) != 0 || obs_cycles != 4 || obs_last_we !== 1'b1 || obs_ready_after !== 1'b1) begin
      errors++;
      $display("FAIL hline_timing: cycles=%0d done_with_we=%b ready_after=%b, required 4 1 1",
               obs_cycles, obs_last_we, obs_ready_after);
    end
  endtask

  task automatic test_zero();
    for (int k = 0; k < 2; k++) begin
      if (k == 0) run_cmd(2'b10, 6'd10, 6'd20, 7'd0, 4'h9);
      else        run_cmd(2'b11, 6'd10, 6'd20, 7'd5, 4'h9);
      checks++;
      if (obs_timeout || obs_addr.size() != 0 || obs_cycles != 1 || obs_last_we !== 1'b0 ||
          obs_busy_bad || obs_ready_after !== 1'b1) begin
        errors++;
        $display("FAIL zero_write k%0d: writes=%0d cycles=%0d we_at_done=%b busy_bad=%b ready_after=%b, required 0 1 0 0 1",
                 k, obs_addr.size(), obs_cycles, obs_last_we, obs_busy_bad, obs_ready_after);
      end
    end
  endtask

  task automatic test_abort();
    int count = 0;
    int guard = 0;
    bit stray = 0;
    cmd_op = 2'b01; cmd_color = 4'h5; cmd_valid = 1'b1;
    while (cmd_ready !== 1'b1 && guard < 100) begin tick(); guard++; end
    tick();
    cmd_valid = 1'b0;
    guard = 0;
    while (guard < 300) begin
      if (we === 1'b1) count++;
      if (count == 100) break;
      guard++;
      tick();
    end
    checks++;
    if (count != 100 || waddr !== 12'd99) begin
      errors++;
      $display("FAIL abort_reach: writes=%0d waddr=%h, required 100 at 063", count, waddr);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (we !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL abort_stop: we=%b done=%b busy=%b ready=%b, required 0 0 0 0",
               we, done, busy, cmd_ready);
    end
    tick();
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (we !== 1'b0 || done !== 1'b0) stray = 1;
      tick();
    end
    checks++;
    if (stray) begin
      errors++;
      $display("FAIL abort_quiet: stray write or done after reset, required none");
    end
    run_cmd(2'b00, 6'd33, 6'd17, 7'd0, 4'hC);
    model(0, 33, 17, 0);
    checks++;
    if (obs_timeout || first_diff() != -1 || din_bad(12) != 0) begin
      errors++;
      $display("FAIL abort_pixel: writes=%0d first=%h, required 1 write at %h",
               obs_addr.size(), obs_addr.size() ? obs_addr[0] : -1, exp_addr[0]);
    end
  endtask

  task automatic test_back_to_back();
    int a_addr = 3 * 64 + 7;
    int b_addr = 50 * 64 + 62;
    cmd_op = 2'b00; cmd_x = 6'd7; cmd_y = 6'd3; cmd_color = 4'h1; cmd_valid = 1'b1;
    tick();
    cmd_x = 6'd62; cmd_y = 6'd50; cmd_color = 4'h2;
    checks++;
    if (we !== 1'b1 || int'(waddr) != a_addr || din !== 4'h1 || cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first: we=%b waddr=%h din=%h ready=%b, required 1 %h 1 0",
               we, waddr, din, cmd_ready, a_addr);
    end
    tick();
    checks++;
    if (we !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_gap: we=%b ready=%b, required 0 1", we, cmd_ready);
    end
    tick();
    cmd_valid = 1'b0;
    checks++;
    if (we !== 1'b1 || int'(waddr) != b_addr || din !== 4'h2) begin
      errors++;
      $display("FAIL b2b_second: we=%b waddr=%h din=%h, required 1 %h 2", we, waddr, din, b_addr);
    end
    tick();
    checks++;
    if (we !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_nodup: we=%b ready=%b, required 0 1", we, cmd_ready);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      int sel = $urandom_range(0, 9);
      int op  = (sel < 4) ? 0 : (sel < 9) ? 2 : 3;
      int x   = $urandom_range(0, 63);
      int y   = $urandom_range(0, 63);
      int len = $urandom_range(0, 64);
      int col = $urandom_range(0, 15);
      int exp_cycles;
      model(op, x, y, len);
      run_cmd(2'(op), 6'(x), 6'(y), 7'(len), 4'(col));
      exp_cycles = (exp_addr.size() == 0) ? 1 : exp_addr.size();
      checks++;
      if (obs_timeout || first_diff() != -1 || din_bad(col) != 0) begin
        errors++;
        $display("FAIL rand%0d_writes: op=%0d x=%0d y=%0d len=%0d got %0d writes diff@%0d, required %0d",
                 n, op, x, y, len, obs_addr.size(), first_diff(), exp_addr.size());
      end
      checks++;
      if (obs_cycles != exp_cycles || obs_last_we !== (exp_addr.size() != 0) ||
          obs_busy_bad || obs_ready_bad || obs_ready_after !== 1'b1) begin
        errors++;
        $display("FAIL rand%0d_timing: cycles=%0d done_with_we=%b ready_after=%b, required %0d %b 1",
                 n, obs_cycles, obs_last_we, obs_ready_after, exp_cycles, exp_addr.size() != 0);
      end
      repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  initial begin
    test_reset();
    test_pixel();
    test_fill();
    test_hline_clip();
    test_zero();
    test_abort();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
